// File: rtl/uart_hamming_pkg.sv
// Shared definitions for the Hamming(7,4) UART link (transmitter and receiver).
// Holds the FSM state encodings, frame geometry and the default bit period.
package uart_hamming_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam int DATA_BITS        = 7;
  localparam int NIBBLE_BITS      = 4;
  localparam int DEFAULT_BIT_CLKS = 8;

endpackage

// File: rtl/uart_hamming_tx_hamming74_enc.sv
// Combinational Hamming(7,4) encoder: cw = {d3, d2, d1, p4, d0, p2, p1}.
// cw[0] is the first bit on the wire.
module hamming74_enc
  import uart_hamming_pkg::*;
(
  input  logic [NIBBLE_BITS-1:0] data,
  output logic [DATA_BITS-1:0]   cw
);

  always_comb begin
    cw[0] = data[0] ^ data[1] ^ data[3];
    cw[1] = data[0] ^ data[2] ^ data[3];
    cw[2] = data[0];
    cw[3] = data[1] ^ data[2] ^ data[3];
    cw[4] = data[1];
    cw[5] = data[2];
    cw[6] = data[3];
  end

endmodule

// File: rtl/uart_hamming_tx.sv
// Hamming(7,4) UART transmitter: start bit, 7 codeword bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to append an even-parity bit after cw[6].
module uart_hamming_tx
  import uart_hamming_pkg::*;
#(
  parameter int BIT_CLKS = uart_hamming_pkg::DEFAULT_BIT_CLKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NIBBLE_BITS-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic [1:0]             state_out,
  output logic                   done_out
);

  // Handshake: a nibble is taken on a rising edge where ena, in_valid and
  // in_ready are all high; in_ready is high only in IDLE, nothing is queued.

  localparam int SCW = $clog2(BIT_CLKS);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif

  logic [1:0]            state_q;
  logic [SCW-1:0]        sample_q;
  logic [2:0]            bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  tx_q;
  logic                  done_q;
  logic [DATA_BITS-1:0]  cw;
  logic [FRAME_BITS-1:0] load_word;
  logic                  bit_end;

  hamming74_enc u_enc (
    .data (in_data),
    .cw   (cw)
  );

`ifdef UART_TX_PARITY_EN
  assign load_word = {^cw, cw};
`else
  assign load_word = cw;
`endif

  assign bit_end = (sample_q == SCW'(BIT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else if (!ena) begin
      // done is a pulse: drop it rather than let it replay when ena returns
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= START;
            tx_q     <= 1'b0;
            shift_q  <= load_word;
            sample_q <= '0;
            bit_q    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            sample_q <= '0;
            bit_q    <= '0;
            state_q  <= DATA;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end else begin
            sample_q <= sample_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            sample_q <= '0;
            if (bit_q == 3'(FRAME_BITS - 1)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            sample_q <= sample_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            sample_q <= '0;
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            sample_q <= sample_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          tx_q     <= 1'b1;
          sample_q <= '0;
          bit_q    <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign tx        = tx_q;
  assign state_out = state_q;
  assign done_out  = done_q && ena;

endmodule

// File: tb/tb_uart_hamming_tx.sv
// Directed bench for uart_hamming_tx: frame shape, encoder table, back-to-back,
// ena stall and mid-frame reset. Honours UART_TX_PARITY_EN.
module tb_uart_hamming_tx;

  localparam int B = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NF = 10;
`else
  localparam int NF = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic       tx;
  logic [1:0] state_out;
  logic       done_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [6:0] cw_tab [0:15];

  uart_hamming_tx #(.BIT_CLKS(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .state_out (state_out),
    .done_out  (done_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected line level for frame bit k (0 = start).
  function automatic logic exp_bit(input logic [6:0] c, input int k);
    if (k == 0) return 1'b0;
    if (k <= 7) return c[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 8) return ^c;
`endif
    return 1'b1;
  endfunction

  // Called in the first cycle after the accept edge; returns in the done cycle.
  task automatic capture_frame(input logic [6:0] c, input string tag);
    logic s [NF*B];
    int   ready_hi = 0;
    int   done_hi  = 0;
    logic got;
    for (int i = 0; i < NF*B; i++) begin
      s[i] = tx;
      if (in_ready) ready_hi++;
      if (done_out) done_hi++;
      tick();
    end
    for (int k = 0; k < NF; k++) begin
      got = exp_bit(c, k);
      for (int j = 0; j < B; j++)
        if (s[k*B+j] !== exp_bit(c, k)) got = s[k*B+j];
      check($sformatf("%s bit%0d", tag, k), 32'(got), 32'(exp_bit(c, k)));
    end
    check({tag, " ready_in_frame"}, ready_hi, 0);
    check({tag, " done_in_frame"}, done_hi, 0);
    check({tag, " done_pulse"}, 32'(done_out), 32'd1);
    check({tag, " state_end"}, 32'(state_out), 32'd0);
  endtask

  // driver: present one nibble from IDLE and let it be accepted
  task automatic send_nibble(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int t1, t2, bad, run, dn;
    logic s2 [NF*B+5];
    logic e;

    cw_tab = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
               7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    // reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst tx", 32'(tx), 32'd1);
    check("rst ready", 32'(in_ready), 32'd1);
    check("rst state", 32'(state_out), 32'd0);
    check("rst done", 32'(done_out), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || in_ready !== 1'b1 || state_out !== 2'b00 || done_out !== 1'b0) bad++;
      tick();
    end
    check("idle stable", bad, 0);

    // single frame 4'hB
    send_nibble(4'hB);
    check("b state_start", 32'(state_out), 32'd1);
    capture_frame(7'h55, "frameB");
    tick();
    check("b done_low_after", 32'(done_out), 32'd0);

    // encoder corners: all 16 nibbles
    for (int n = 0; n < 16; n++) begin
      send_nibble(4'(n));
      capture_frame(cw_tab[n], $sformatf("enc%0h", n));
      tick();
    end

    // back-to-back with in_valid held high
    in_data  = 4'h3;
    in_valid = 1'b1;
    tick();
    in_data = 4'hC;
    t1 = cyc;
    capture_frame(7'h1E, "b2b_3");
    tick();
    in_valid = 1'b0;
    t2 = cyc;
    check("b2b period", t2 - t1, NF*B + 1);
    capture_frame(7'h61, "b2b_C");
    tick();

    // ena stall for 5 cycles inside cw[3]
    send_nibble(4'hB);
    dn = 0;
    for (int i = 0; i < NF*B + 5; i++) begin
      ena = !(i >= 34 && i <= 38);
      s2[i] = tx;
      if (i == 36) check("stall state", 32'(state_out), 32'd2);
      if (done_out) dn++;
      tick();
    end
    ena = 1'b1;
    check("stall done_pulse", 32'(done_out), 32'd1);
    check("stall done_in_frame", dn, 0);
    bad = 0;
    for (int i = 0; i < NF*B + 5; i++) begin
      e = exp_bit(7'h55, ((i < 40) ? i : ((i < 45) ? 39 : i - 5)) / B);
      if (s2[i] !== e) bad++;
    end
    check("stall stream", bad, 0);
    run = 0;
    for (int i = 32; i < NF*B; i++) begin
      if (s2[i] !== 1'b0) break;
      run++;
    end
    check("stall cw3_len", run, 13);
    tick();

    // reset in DATA
    send_nibble(4'h0);
    for (int i = 0; i < 20; i++) tick();
    check("mrst pre_tx", 32'(tx), 32'd0);
    check("mrst pre_state", 32'(state_out), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst tx", 32'(tx), 32'd1);
    check("mrst state", 32'(state_out), 32'd0);
    check("mrst ready", 32'(in_ready), 32'd1);
    bad = 0;
    dn  = 0;
    for (int i = 0; i < NF*B; i++) begin
      if (tx !== 1'b1) bad++;
      if (done_out) dn++;
      tick();
    end
    check("mrst idle_tx", bad, 0);
    check("mrst no_done", dn, 0);

    // recovery frame
    send_nibble(4'h5);
    capture_frame(7'h2D, "recover5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
